// File: rtl/stream_arbiter_ctrl.sv
// stream_arbiter_ctrl: packet-level QoS arbiter sharing one master stream among STREAM_COUNT slaves.
// Define STREAM_ARB_RR_TIEBREAK_EN for round-robin tie-break among equal-QoS streams (default: lowest index).
module stream_arbiter_ctrl #(
   parameter  int T_DATA_WIDTH = 8,
   parameter  int T_QOS__WIDTH = 4,
   parameter  int STREAM_COUNT = 2,
   localparam int IW           = $clog2(STREAM_COUNT) + 1
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
   input  logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0] s_qos_i,
   input  logic [STREAM_COUNT-1:0]                   s_valid_i,
   input  logic [STREAM_COUNT-1:0]                   s_last_i,
   output logic [STREAM_COUNT-1:0]                   s_ready_o,
   output logic [T_DATA_WIDTH-1:0]                   m_data_o,
   output logic                                      m_valid_o,
   output logic                                      m_last_o,
   input  logic                                      m_ready_i,
   output logic [IW-1:0]                             m_id_o,
   output logic [T_QOS__WIDTH-1:0]                   m_qos_o
);

   typedef enum logic {ST_IDLE, ST_GRANT} state_t;

   state_t                  state_q;
   logic [IW-1:0]           grant_idx_q;
   logic [T_QOS__WIDTH-1:0] qos_q;

   logic [IW-1:0]           grant_idx_d;
   logic [T_QOS__WIDTH-1:0] qos_d;
   logic                    win_found;
   int                      win_dist;
   int                      cand_dist;
   logic [STREAM_COUNT-1:0] sel;
   logic                    pkt_end;

`ifdef STREAM_ARB_RR_TIEBREAK_EN
   logic [IW-1:0] last_grant_q;
   int            rr_start;

   assign rr_start = (int'(last_grant_q) >= STREAM_COUNT - 1) ? 0 : int'(last_grant_q) + 1;
`endif

   // Highest QoS wins; among equals the smallest distance from the scan start wins.
   always_comb begin
      win_found   = 1'b0;
      grant_idx_d = IW'(STREAM_COUNT);
      qos_d       = '0;
      win_dist    = 0;
      cand_dist   = 0;
      for (int i = 0; i < STREAM_COUNT; i++) begin
`ifdef STREAM_ARB_RR_TIEBREAK_EN
         cand_dist = i - rr_start;
         if (cand_dist < 0) cand_dist = cand_dist + STREAM_COUNT;
`else
         cand_dist = i;
`endif
         if (s_valid_i[i] && (!win_found || (s_qos_i[i] > qos_d) ||
                              ((s_qos_i[i] == qos_d) && (cand_dist < win_dist)))) begin
            win_found   = 1'b1;
            grant_idx_d = IW'(i);
            qos_d       = s_qos_i[i];
            win_dist    = cand_dist;
         end
      end
   end

   for (genvar gi = 0; gi < STREAM_COUNT; gi++) begin : g_sel
      assign sel[gi]       = (state_q == ST_GRANT) && (grant_idx_q == IW'(gi));
      assign s_ready_o[gi] = sel[gi] & m_ready_i;
   end

   // Data path is unregistered: the granted source sees backpressure in the same cycle.
   always_comb begin
      m_data_o  = '0;
      m_last_o  = 1'b0;
      m_valid_o = 1'b0;
      for (int i = 0; i < STREAM_COUNT; i++) begin
         if (sel[i]) begin
            m_data_o  = s_data_i[i];
            m_last_o  = s_last_i[i];
            m_valid_o = s_valid_i[i];
         end
      end
   end

   assign pkt_end = m_valid_o & m_ready_i & m_last_o;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         grant_idx_q  <= IW'(STREAM_COUNT);
         qos_q        <= '0;
`ifdef STREAM_ARB_RR_TIEBREAK_EN
         last_grant_q <= IW'(STREAM_COUNT - 1);
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|s_valid_i) begin
                  state_q     <= ST_GRANT;
                  grant_idx_q <= grant_idx_d;
                  qos_q       <= qos_d;
               end
            end
            ST_GRANT: begin
               if (pkt_end) begin
                  state_q      <= ST_IDLE;
                  grant_idx_q  <= IW'(STREAM_COUNT);
`ifdef STREAM_ARB_RR_TIEBREAK_EN
                  last_grant_q <= grant_idx_q;
`endif
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign m_id_o  = grant_idx_q;
   assign m_qos_o = qos_q;

endmodule

// File: tb/tb_stream_arbiter_ctrl.sv
// Scoreboard bench for stream_arbiter_ctrl: sources replay packet queues, output beats are checked in order.
// Tie-break expectations follow STREAM_ARB_RR_TIEBREAK_EN when it is defined for the build.
module tb_stream_arbiter_ctrl;
   localparam int DW = 8;
   localparam int QW = 4;
   localparam int N  = 2;
   localparam int IW = $clog2(N) + 1;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [N-1:0][DW-1:0]   s_data_i;
   logic [N-1:0][QW-1:0]   s_qos_i;
   logic [N-1:0]           s_valid_i;
   logic [N-1:0]           s_last_i;
   logic [N-1:0]           s_ready_o;
   logic [DW-1:0]          m_data_o;
   logic                   m_valid_o;
   logic                   m_last_o;
   logic                   m_ready_i;
   logic [IW-1:0]          m_id_o;
   logic [QW-1:0]          m_qos_o;

   stream_arbiter_ctrl #(.T_DATA_WIDTH(DW), .T_QOS__WIDTH(QW), .STREAM_COUNT(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_data_i(s_data_i), .s_qos_i(s_qos_i), .s_valid_i(s_valid_i), .s_last_i(s_last_i),
      .s_ready_o(s_ready_o),
      .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i),
      .m_id_o(m_id_o), .m_qos_o(m_qos_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      logic [QW-1:0] qos;
   } beat_t;

   typedef struct {
      logic [IW-1:0] id;
      logic [QW-1:0] qos;
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   beat_t src0_q[$];
   beat_t src1_q[$];
   exp_t  exp_q[$];

   int            n_checks = 0;
   int            n_pass   = 0;
   logic [N-1:0]  drop;
   logic [N-1:0]  hs;
   logic          gap_pend, stall_pend, drop_chk, rst_chk;
   logic [DW-1:0] stall_data;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic src_pkt(input int s, input logic [QW-1:0] qos, input logic [DW-1:0] base, input int len);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         b.data = base + DW'(k);
         b.last = (k == len - 1);
         b.qos  = qos;
         if (s == 0) src0_q.push_back(b);
         else        src1_q.push_back(b);
      end
   endtask

   task automatic exp_pkt(input int s, input logic [QW-1:0] qos, input logic [DW-1:0] base, input int len);
      exp_t e;
      for (int k = 0; k < len; k++) begin
         e.id   = IW'(s);
         e.qos  = qos;
         e.data = base + DW'(k);
         e.last = (k == len - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic drive();
      s_valid_i = '0;
      s_data_i  = '0;
      s_last_i  = '0;
      s_qos_i   = '0;
      if (src0_q.size() > 0) begin
         s_valid_i[0] = !drop[0];
         s_data_i[0]  = src0_q[0].data;
         s_last_i[0]  = src0_q[0].last;
         s_qos_i[0]   = src0_q[0].qos;
      end
      if (src1_q.size() > 0) begin
         s_valid_i[1] = !drop[1];
         s_data_i[1]  = src1_q[0].data;
         s_last_i[1]  = src1_q[0].last;
         s_qos_i[1]   = src1_q[0].qos;
      end
   endtask

   task automatic monitor();
      exp_t         e;
      logic [N-1:0] rdy_exp;
      hs = s_valid_i & s_ready_o;
      if (rst_chk) begin
         check("rst_valid", m_valid_o, 0);
         check("rst_id", m_id_o, N);
         check("rst_sready", s_ready_o, 0);
      end
      if (drop_chk) begin
         check("drop_id", m_id_o, 0);
         check("drop_valid", m_valid_o, 0);
      end
      if (gap_pend) begin
         check("gap_valid", m_valid_o, 0);
         check("gap_id", m_id_o, N);
      end
      if (stall_pend) check("stall_data", m_data_o, stall_data);
      if (m_valid_o && m_ready_i) begin
         if (exp_q.size() == 0) begin
            check("extra_beat_id", m_id_o, N);
         end else begin
            e = exp_q.pop_front();
            rdy_exp = '0;
            rdy_exp[e.id] = 1'b1;
            $display("beat id=%0d qos=%0d data=0x%02h last=%0b", m_id_o, m_qos_o, m_data_o, m_last_o);
            check("beat_id", m_id_o, e.id);
            check("beat_qos", m_qos_o, e.qos);
            check("beat_data", m_data_o, e.data);
            check("beat_last", m_last_o, e.last);
            check("beat_sready", s_ready_o, rdy_exp);
         end
      end
      gap_pend = rst_n && m_valid_o && m_ready_i && m_last_o;
      if (m_valid_o && !m_ready_i) begin
         check("stall_sready", s_ready_o, 0);
         stall_pend = 1'b1;
         stall_data = m_data_o;
      end else begin
         stall_pend = 1'b0;
      end
   endtask

   task automatic cycle();
      drive();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      if (hs[0] === 1'b1) src0_q.delete(0);
      if (hs[1] === 1'b1) src1_q.delete(0);
   endtask

   task automatic do_reset();
      src0_q.delete();
      src1_q.delete();
      exp_q.delete();
      drop       = '0;
      hs         = '0;
      m_ready_i  = 1'b1;
      gap_pend   = 1'b0;
      stall_pend = 1'b0;
      drop_chk   = 1'b0;
      rst_chk    = 1'b0;
      rst_n      = 1'b0;
      cycle();
      cycle();
      rst_n   = 1'b1;
      rst_chk = 1'b1;
      cycle();
      rst_chk = 1'b0;
      check("rst_qos", m_qos_o, 0);
   endtask

   initial begin
      int cyc;

      // Priority: QoS 9 beats QoS 3, one idle cycle between packets.
      do_reset();
      src_pkt(0, 3, 8'h10, 3);
      src_pkt(1, 9, 8'h20, 3);
      exp_pkt(1, 9, 8'h20, 3);
      exp_pkt(0, 3, 8'h10, 3);
      for (cyc = 0; cyc < 100 && exp_q.size() != 0; cyc++) cycle();
      check("prio_cycles", cyc, 8);
      check("prio_drain", exp_q.size(), 0);

      // Packet lock: a QoS 15 arrival mid-packet waits for the last beat.
      do_reset();
      src_pkt(0, 2, 8'h30, 4);
      exp_pkt(0, 2, 8'h30, 4);
      for (cyc = 0; cyc < 100 && exp_q.size() != 0; cyc++) begin
         if (cyc == 2) begin
            src_pkt(1, 15, 8'h40, 2);
            exp_pkt(1, 15, 8'h40, 2);
         end
         cycle();
      end
      check("lock_cycles", cyc, 8);
      check("lock_drain", exp_q.size(), 0);

      // Tie at QoS 5 with back-to-back single-beat packets.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         src_pkt(0, 5, 8'h50 + 8'(k), 1);
         src_pkt(1, 5, 8'h60 + 8'(k), 1);
`ifdef STREAM_ARB_RR_TIEBREAK_EN
         exp_pkt(0, 5, 8'h50 + 8'(k), 1);
         exp_pkt(1, 5, 8'h60 + 8'(k), 1);
`endif
      end
`ifndef STREAM_ARB_RR_TIEBREAK_EN
      for (int k = 0; k < 4; k++) exp_pkt(0, 5, 8'h50 + 8'(k), 1);
      for (int k = 0; k < 4; k++) exp_pkt(1, 5, 8'h60 + 8'(k), 1);
`endif
      for (cyc = 0; cyc < 100 && exp_q.size() != 0; cyc++) cycle();
      check("tie_cycles", cyc, 16);
      check("tie_drain", exp_q.size(), 0);

      // Backpressure: three stalled cycles on the second beat.
      do_reset();
      src_pkt(0, 1, 8'h70, 4);
      exp_pkt(0, 1, 8'h70, 4);
      for (cyc = 0; cyc < 100 && exp_q.size() != 0; cyc++) begin
         m_ready_i = !(cyc >= 2 && cyc <= 4);
         cycle();
      end
      m_ready_i = 1'b1;
      check("bp_cycles", cyc, 8);
      check("bp_drain", exp_q.size(), 0);

      // Valid drop: grant is held while stream 1 waits with higher QoS.
      do_reset();
      src_pkt(0, 2, 8'h80, 3);
      exp_pkt(0, 2, 8'h80, 3);
      for (cyc = 0; cyc < 100 && exp_q.size() != 0; cyc++) begin
         if (cyc == 1) begin
            src_pkt(1, 9, 8'h90, 2);
            exp_pkt(1, 9, 8'h90, 2);
         end
         drop[0]  = (cyc == 2 || cyc == 3);
         drop_chk = drop[0];
         cycle();
      end
      drop     = '0;
      drop_chk = 1'b0;
      check("drop_cycles", cyc, 9);
      check("drop_drain", exp_q.size(), 0);

      // Reset mid-packet on stream 1; the rest is re-granted right after release.
      do_reset();
      src_pkt(1, 7, 8'hA0, 6);
      exp_pkt(1, 7, 8'hA0, 6);
      for (cyc = 0; cyc < 100 && exp_q.size() != 0; cyc++) begin
         rst_n   = (cyc != 3);
         rst_chk = (cyc == 4);
         cycle();
      end
      rst_n   = 1'b1;
      rst_chk = 1'b0;
      check("rstmid_cycles", cyc, 8);
      check("rstmid_drain", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
